// File: rtl/rc5_key_expand_if.sv
// rc5_key_expand_if: key-load and subkey-read bus between the RC5 core and its key-schedule engine.
interface rc5_key_expand_if #(
    parameter int WORD_SIZE = 32,
    parameter int KEY_BYTES = 16
);
    logic [8*KEY_BYTES-1:0] key_in;
    logic                   start;
    logic                   busy;
    logic                   key_valid;
    logic [4:0]             skey_addr;
    logic [WORD_SIZE-1:0]   skey_data;
    modport master (output key_in, start, skey_addr, input busy, key_valid, skey_data);
    modport slave  (input key_in, start, skey_addr, output busy, key_valid, skey_data);
endinterface

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5-32 key schedule, expands the secret key into subkey table S[0..T-1].
module rc5_key_expand #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_ROUNDS = 12,
    parameter int KEY_BYTES  = 16
) (
    input logic              clk,
    input logic              rst,
    rc5_key_expand_if.slave  bus
);
    localparam int T  = 2*NUM_ROUNDS + 2;
    localparam int C  = KEY_BYTES / 4;
    localparam int N  = 3 * (T > C ? T : C);
    localparam int IW = $clog2(T);
    localparam int JW = C > 1 ? $clog2(C) : 1;
    localparam int CW = $clog2(N);
    localparam int SW = $clog2(WORD_SIZE);
    localparam logic [WORD_SIZE-1:0] P = 32'hB7E15163;
    localparam logic [WORD_SIZE-1:0] Q = 32'h9E3779B9;

    typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, DONE} state_t;

    state_t                r_state, w_next;
    logic [WORD_SIZE-1:0]  r_s [T];
    logic [WORD_SIZE-1:0]  r_l [C];
    logic [WORD_SIZE-1:0]  r_a, r_b, r_dout;
    logic [IW-1:0]         r_i;
    logic [JW-1:0]         r_j;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy, r_valid;
    logic                  w_load;
    logic [WORD_SIZE-1:0]  w_init, w_sa, w_a, w_ab, w_b;

    // Rotating a doubled word keeps a zero amount free of any shift-by-width term.
    function automatic logic [WORD_SIZE-1:0] rol(input logic [WORD_SIZE-1:0] x, input logic [SW-1:0] sh);
        logic [2*WORD_SIZE-1:0] d;
        d = {x, x} << sh;
        return d[2*WORD_SIZE-1:WORD_SIZE];
    endfunction

    assign w_load = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_init = r_i == '0 ? P : r_s[r_i - IW'(1)] + Q;
    assign w_sa   = r_s[r_i] + r_a + r_b;
    assign w_a    = rol(w_sa, SW'(3));
    assign w_ab   = w_a + r_b;
    assign w_b    = rol(r_l[r_j] + w_ab, w_ab[SW-1:0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = bus.start ? LOAD : r_state;
            LOAD:       w_next = INIT;
            INIT:       w_next = r_i == IW'(T-1) ? MIX : INIT;
            MIX:        w_next = r_cnt == CW'(N-1) ? DONE : MIX;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != IDLE && !(r_state == DONE && w_next == DONE);
            r_valid <= r_state == DONE && w_next == DONE;
            r_dout  <= bus.skey_addr < 5'(T) ? r_s[IW'(bus.skey_addr)] : '0;
            if (r_state == LOAD) begin
                r_a   <= '0;
                r_b   <= '0;
                r_i   <= '0;
                r_j   <= '0;
                r_cnt <= '0;
            end else if (r_state == INIT) begin
                r_i <= r_i == IW'(T-1) ? '0 : r_i + IW'(1);
            end else if (r_state == MIX) begin
                r_a   <= w_a;
                r_b   <= w_b;
                r_i   <= r_i == IW'(T-1) ? '0 : r_i + IW'(1);
                r_j   <= r_j == JW'(C-1) ? '0 : r_j + JW'(1);
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Table storage carries no reset; every run rebuilds it from scratch.
    always_ff @(posedge clk) begin
        if (r_state == INIT)
            r_s[r_i] <= w_init;
        else if (r_state == MIX)
            r_s[r_i] <= w_a;
        if (w_load)
            for (int k = 0; k < C; k++) r_l[k] <= bus.key_in[WORD_SIZE*k +: WORD_SIZE];
        else if (r_state == MIX)
            r_l[r_j] <= w_b;
    end

    assign bus.busy      = r_busy;
    assign bus.key_valid = r_valid;
    assign bus.skey_data = r_dout;
endmodule

// File: tb/tb_rc5_key_expand.sv
// tb_rc5_key_expand: directed bench for the RC5-32/12/16 key schedule with a reference model and read scoreboard.
module tb_rc5_key_expand;
    localparam int T = 26;
    typedef logic [31:0] tab_t [T];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] sb [$];
    tab_t rd_tab;

    rc5_key_expand_if #(.WORD_SIZE(32), .KEY_BYTES(16)) bus ();
    rc5_key_expand #(.WORD_SIZE(32), .NUM_ROUNDS(12), .KEY_BYTES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] sh);
        return sh == 0 ? x : (x << sh) | (x >> (6'd32 - {1'b0, sh}));
    endfunction

    function automatic tab_t model(input logic [127:0] k);
        tab_t s;
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int n = 0; n < 4; n++)
            l[n] = {k[8*(4*n+3) +: 8], k[8*(4*n+2) +: 8], k[8*(4*n+1) +: 8], k[8*(4*n) +: 8]};
        s[0] = 32'hB7E15163;
        for (int n = 1; n < T; n++) s[n] = s[n-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < 3*T; n++) begin
            a = rol(s[i] + a + b, 5'd3);
            s[i] = a;
            b = rol(l[j] + a + b, 5'((a + b) & 32'h1F));
            l[j] = b;
            i = (i + 1) % T;
            j = (j + 1) % 4;
        end
        return s;
    endfunction

    function automatic logic [63:0] enc(input tab_t s);
        logic [31:0] a, b;
        a = s[0];
        b = s[1];
        for (int r = 1; r <= 12; r++) begin
            a = rol(a ^ b, b[4:0]) + s[2*r];
            b = rol(b ^ a, a[4:0]) + s[2*r+1];
        end
        return {a, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty got=%h", tag, bus.skey_data);
        end else
            chk(tag, bus.skey_data, sb.pop_front());
    endtask

    task automatic read_all(input tab_t exp, input string tag);
        for (int a = 0; a <= 32; a++) begin
            @(negedge clk);
            if (a > 0) begin
                if (a - 1 < T) rd_tab[a-1] = bus.skey_data;
                pop_chk($sformatf("%s[%0d]", tag, a - 1));
            end
            if (a < 32) begin
                bus.skey_addr = 5'(a);
                sb.push_back(a < T ? exp[a] : 32'h0);
            end
        end
    endtask

    task automatic run_key(input logic [127:0] k, input bit probe, input bit pulses, input int rst_at,
                           input logic [127:0] junk);
        logic [31:0] zi [3];
        int c;
        bit done;
        zi = '{32'hB7E15163, 32'h5618CB1C, 32'hF45044D5};
        bus.key_in = k;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.key_in = junk;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("valid_after_start", 32'(bus.key_valid), 32'd0);
        c = 0;
        done = 1'b0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            bus.start = pulses && (c == 5 || c == 40 || c == 90);
            if (probe && c >= 6 && c <= 8) pop_chk($sformatf("probe_s%0d", c - 6));
            if (probe && c >= 5 && c <= 7) begin
                bus.skey_addr = 5'(c - 5);
                sb.push_back(zi[c-5]);
            end
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_busy", 32'(bus.busy), 32'd0);
                chk("rst_mid_valid", 32'(bus.key_valid), 32'd0);
                chk("rst_mid_data", bus.skey_data, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            done = bus.key_valid;
        end
        chk("valid_latency", 32'(c), 32'd106);
        chk("busy_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [127:0] k16, kr;
        logic [63:0] ct;
        for (int b = 0; b < 16; b++) k16[8*b +: 8] = 8'(b);
        kr = {$urandom, $urandom, $urandom, $urandom};
        bus.key_in = '0;
        bus.start = 1'b0;
        bus.skey_addr = '0;
        #7 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.key_valid), 32'd0);
        chk("rst_data", bus.skey_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_key('0, 1'b1, 1'b0, -1, '0);
        read_all(model('0), "zero");
        ct = enc(rd_tab);
        chk("ct_a", ct[63:32], 32'hEEDBA521);
        chk("ct_b", ct[31:0], 32'h6D8F4B15);

        run_key(k16, 1'b0, 1'b0, -1, ~k16);
        read_all(model(k16), "k16");

        run_key(k16, 1'b0, 1'b1, -1, kr);
        read_all(model(k16), "k16_pulses");

        run_key(kr, 1'b0, 1'b0, -1, k16);
        read_all(model(kr), "krand");

        run_key(k16, 1'b0, 1'b0, 68, kr);
        run_key(k16, 1'b0, 1'b0, -1, kr);
        read_all(model(k16), "k16_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
